gen_rr_arbiter: RTL and testbench

Parameterised round-robin arbiter sharing one downstream resource among N requesters, such as the array of `sub` instances built by a generate loop. It registers a one-hot grant, holds it while the owner keeps its request high, and optionally preempts the owner after a burst limit so that waiting requesters are served. Per-requester priority/mask logic is built with a generate-for loop. The burst limiter exists only when `MAX_BURST > 0`, selected with a generate-if.

---
 rtl/gen_rr_arbiter_if.sv | 18 +
 rtl/gen_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_gen_rr_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/gen_rr_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// Latency: none, this is wiring only.
// Backpressure: a requester keeps its req bit high until it has finished with the resource.
interface gen_rr_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           preempt;

  // Requester side: raises requests and observes the grant.
  modport master (output req, input gnt, gnt_valid, gnt_id, preempt);
  // Arbiter side: samples requests and drives the grant.
  modport slave  (input req, output gnt, gnt_valid, gnt_id, preempt);
endinterface

// File: rtl/gen_rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant shared by N requesters, with an optional burst limit.
// Latency: 1 cycle from req to gnt; a released grant moves to the next requester at the same edge.
// Backpressure: the owner keeps gnt while req stays high, unless MAX_BURST expires with others waiting.
module gen_rr_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 8,
  parameter int IDW       = $clog2(N)
) (
  input logic           clk,
  input logic           rst,
  gen_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [N-1:0]   gnt_q;
  logic           gnt_valid_q;
  logic [IDW-1:0] gnt_id_q;
  logic           preempt_q;
  logic [IDW-1:0] ptr;

  logic [N-1:0]   cand;
  logic [N-1:0]   hi_req;
  logic [N-1:0]   winner_oh;
  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] any_idx;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] ptr_nxt;
  logic           found;
  logic           hi_found;
  logic           owner_req;
  logic           burst_hit;
  logic           take;
  logic           hold;
  logic           do_preempt;

  // While granting, ptr already sits at owner+1, so excluding the owner and searching
  // from ptr covers both the release search and the burst handover search.
  assign owner_req = |(bus.req & gnt_q);
  assign cand      = (state == GRANT) ? (bus.req & ~gnt_q) : bus.req;

  // Per-requester mask: candidates at or above ptr win before the wrapped-around ones.
  for (genvar i = 0; i < N; i++) begin : g_mask
    assign hi_req[i]    = cand[i] & (IDW'(i) >= ptr);
    assign winner_oh[i] = (winner == IDW'(i));
  end

  // Two lowest-index priority encoders: one over the masked upper half, one over all candidates.
  always_comb begin
    hi_idx  = '0;
    any_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hi_req[i]) hi_idx = IDW'(i);
      if (cand[i])   any_idx = IDW'(i);
    end
  end

  assign found    = |cand;
  assign hi_found = |hi_req;
  assign winner   = hi_found ? hi_idx : any_idx;
  assign ptr_nxt  = (winner == IDW'(N - 1)) ? '0 : winner + IDW'(1);

  // Decide between a new grant, holding the current owner, or going idle.
  always_comb begin
    take       = 1'b0;
    hold       = 1'b0;
    do_preempt = 1'b0;
    if (state == IDLE) begin
      take = found;
    end else if (!owner_req) begin
      take = found;
    end else if (burst_hit && found) begin
      take       = 1'b1;
      do_preempt = 1'b1;
    end else begin
      hold = 1'b1;
    end
  end

  if (MAX_BURST > 0) begin : g_burst
    logic [7:0] cnt;

    // Burst counter: 1 on a fresh grant, saturating count while held, cleared when idle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (take) begin
        cnt <= 8'd1;
      end else if (hold) begin
        if (cnt != 8'(MAX_BURST)) cnt <= cnt + 8'd1;
      end else begin
        cnt <= '0;
      end
    end

    assign burst_hit = (cnt == 8'(MAX_BURST));
  end else begin : g_no_burst
    assign burst_hit = 1'b0;
  end

  // Arbitration FSM with registered grant outputs; gnt_id keeps its value while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      preempt_q   <= 1'b0;
      ptr         <= '0;
    end else begin
      preempt_q <= do_preempt;
      if (take) begin
        state       <= GRANT;
        gnt_q       <= winner_oh;
        gnt_valid_q <= 1'b1;
        gnt_id_q    <= winner;
        ptr         <= ptr_nxt;
      end else if (!hold) begin
        state       <= IDLE;
        gnt_q       <= '0;
        gnt_valid_q <= 1'b0;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_gen_rr_arbiter.sv
// Directed bench for gen_rr_arbiter: a MAX_BURST=8 and a MAX_BURST=0 instance see the same requests.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: requesters hold req high for as long as each scenario needs the resource.
module tb_gen_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  gen_rr_arbiter_if #(.N(4)) bus8 ();
  gen_rr_arbiter_if #(.N(4)) bus0 ();

  gen_rr_arbiter #(.N(4), .MAX_BURST(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  gen_rr_arbiter #(.N(4), .MAX_BURST(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    bus8.req = r;
    bus0.req = r;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    set_req(4'b0000);
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Outputs are idle during reset even with every request high.
  task automatic test_reset;
    rst = 1'b1;
    set_req(4'b1111);
    tick;
    tick;
    vectors++; if (bus8.gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt8: got %b want 0000", bus8.gnt); end
    vectors++; if (bus8.gnt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid8: got %b want 0", bus8.gnt_valid); end
    vectors++; if (bus8.gnt_id !== 2'd0) begin miscompares++; $display("FAIL reset_id8: got %0d want 0", bus8.gnt_id); end
    vectors++; if (bus8.preempt !== 1'b0) begin miscompares++; $display("FAIL reset_preempt8: got %b want 0", bus8.preempt); end
    vectors++; if (bus0.gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt0: got %b want 0000", bus0.gnt); end
    rst = 1'b0;
    set_req(4'b0000);
    tick;
  endtask

  // Single request, release to idle, then ptr=3 makes requester 3 beat requester 0.
  task automatic test_single_request;
    set_req(4'b0100);
    tick;
    vectors++; if (bus8.gnt !== 4'b0100) begin miscompares++; $display("FAIL single_gnt: got %b want 0100", bus8.gnt); end
    vectors++; if (bus8.gnt_id !== 2'd2) begin miscompares++; $display("FAIL single_id: got %0d want 2", bus8.gnt_id); end
    vectors++; if (bus8.gnt_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", bus8.gnt_valid); end
    tick;
    vectors++; if (bus8.gnt !== 4'b0100) begin miscompares++; $display("FAIL single_hold: got %b want 0100", bus8.gnt); end
    set_req(4'b0000);
    tick;
    vectors++; if (bus8.gnt !== 4'b0000) begin miscompares++; $display("FAIL single_release: got %b want 0000", bus8.gnt); end
    vectors++; if (bus8.gnt_valid !== 1'b0) begin miscompares++; $display("FAIL single_rel_valid: got %b want 0", bus8.gnt_valid); end
    vectors++; if (bus8.gnt_id !== 2'd2) begin miscompares++; $display("FAIL single_id_hold: got %0d want 2", bus8.gnt_id); end
    set_req(4'b1001);
    tick;
    vectors++; if (bus8.gnt !== 4'b1000) begin miscompares++; $display("FAIL single_ptr3: got %b want 1000", bus8.gnt); end
    set_req(4'b0000);
    tick;
  endtask

  // All four requesting: 8-cycle slots in order 0,1,2,3,0 with a preempt pulse per handover.
  task automatic test_simultaneous;
    logic [3:0] exp_gnt;
    logic       exp_pre;
    do_reset;
    set_req(4'b1111);
    for (int c = 0; c < 40; c++) begin
      tick;
      exp_gnt = 4'b0001 << ((c / 8) % 4);
      exp_pre = (c > 0) && (c % 8 == 0);
      vectors++; if (bus8.gnt !== exp_gnt) begin miscompares++; $display("FAIL all_gnt c=%0d: got %b want %b", c, bus8.gnt, exp_gnt); end
      vectors++; if (bus8.preempt !== exp_pre) begin miscompares++; $display("FAIL all_preempt c=%0d: got %b want %b", c, bus8.preempt, exp_pre); end
      vectors++; if (bus0.gnt !== 4'b0001) begin miscompares++; $display("FAIL all_nolimit c=%0d: got %b want 0001", c, bus0.gnt); end
    end
    set_req(4'b0000);
    tick;
  endtask

  // Owner 1 releases with 3 and 0 waiting: search from 2 picks 3 with no idle bubble.
  task automatic test_release_handover;
    do_reset;
    set_req(4'b0010);
    tick;
    vectors++; if (bus8.gnt !== 4'b0010) begin miscompares++; $display("FAIL rel_owner1: got %b want 0010", bus8.gnt); end
    set_req(4'b1011);
    tick;
    tick;
    vectors++; if (bus8.gnt !== 4'b0010) begin miscompares++; $display("FAIL rel_keep: got %b want 0010", bus8.gnt); end
    set_req(4'b1001);
    tick;
    vectors++; if (bus8.gnt !== 4'b1000) begin miscompares++; $display("FAIL rel_next: got %b want 1000", bus8.gnt); end
    vectors++; if (bus8.gnt_id !== 2'd3) begin miscompares++; $display("FAIL rel_id: got %0d want 3", bus8.gnt_id); end
    vectors++; if (bus8.preempt !== 1'b0) begin miscompares++; $display("FAIL rel_preempt: got %b want 0", bus8.preempt); end
    vectors++; if (bus0.gnt !== 4'b1000) begin miscompares++; $display("FAIL rel_next0: got %b want 1000", bus0.gnt); end
    set_req(4'b0000);
    tick;
  endtask

  // Lone owner keeps the grant; the saturated count preempts as soon as a rival appears.
  task automatic test_lone_owner;
    set_req(4'b1000);
    for (int c = 0; c < 40; c++) begin
      tick;
      vectors++; if (bus8.gnt !== 4'b1000) begin miscompares++; $display("FAIL lone_gnt c=%0d: got %b want 1000", c, bus8.gnt); end
      vectors++; if (bus8.preempt !== 1'b0) begin miscompares++; $display("FAIL lone_preempt c=%0d: got %b want 0", c, bus8.preempt); end
    end
    set_req(4'b1001);
    tick;
    vectors++; if (bus8.gnt !== 4'b0001) begin miscompares++; $display("FAIL lone_sat_handover: got %b want 0001", bus8.gnt); end
    vectors++; if (bus8.preempt !== 1'b1) begin miscompares++; $display("FAIL lone_sat_preempt: got %b want 1", bus8.preempt); end
    vectors++; if (bus0.gnt !== 4'b1000) begin miscompares++; $display("FAIL lone_nolimit: got %b want 1000", bus0.gnt); end
    vectors++; if (bus0.preempt !== 1'b0) begin miscompares++; $display("FAIL lone_nolimit_pre: got %b want 0", bus0.preempt); end
    set_req(4'b0000);
    tick;
    vectors++; if (bus8.preempt !== 1'b0) begin miscompares++; $display("FAIL lone_pulse_width: got %b want 0", bus8.preempt); end
    vectors++; if (bus8.gnt !== 4'b0000) begin miscompares++; $display("FAIL lone_idle: got %b want 0000", bus8.gnt); end
  endtask

  // Unlimited build: requester 0 holds until it releases, then 1 follows one cycle later.
  task automatic test_max_burst0;
    do_reset;
    set_req(4'b0011);
    for (int c = 0; c < 20; c++) begin
      tick;
      vectors++; if (bus0.gnt !== 4'b0001) begin miscompares++; $display("FAIL mb0_hold c=%0d: got %b want 0001", c, bus0.gnt); end
      vectors++; if (bus0.preempt !== 1'b0) begin miscompares++; $display("FAIL mb0_preempt c=%0d: got %b want 0", c, bus0.preempt); end
    end
    set_req(4'b0010);
    tick;
    vectors++; if (bus0.gnt !== 4'b0010) begin miscompares++; $display("FAIL mb0_next: got %b want 0010", bus0.gnt); end
    vectors++; if (bus0.gnt_id !== 2'd1) begin miscompares++; $display("FAIL mb0_id: got %0d want 1", bus0.gnt_id); end
    set_req(4'b0000);
    tick;
    vectors++; if (bus0.gnt !== 4'b0000) begin miscompares++; $display("FAIL mb0_idle: got %b want 0000", bus0.gnt); end
  endtask

  // Reset mid-burst clears the grant between edges; afterwards requester 0 has top priority.
  task automatic test_async_reset;
    do_reset;
    set_req(4'b0010);
    tick;
    tick;
    vectors++; if (bus8.gnt !== 4'b0010) begin miscompares++; $display("FAIL arst_pre: got %b want 0010", bus8.gnt); end
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (bus8.gnt !== 4'b0000) begin miscompares++; $display("FAIL arst_gnt8: got %b want 0000", bus8.gnt); end
    vectors++; if (bus8.gnt_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid8: got %b want 0", bus8.gnt_valid); end
    vectors++; if (bus8.gnt_id !== 2'd0) begin miscompares++; $display("FAIL arst_id8: got %0d want 0", bus8.gnt_id); end
    vectors++; if (bus0.gnt !== 4'b0000) begin miscompares++; $display("FAIL arst_gnt0: got %b want 0000", bus0.gnt); end
    #1;
    set_req(4'b0011);
    rst = 1'b0;
    tick;
    vectors++; if (bus8.gnt !== 4'b0001) begin miscompares++; $display("FAIL arst_restart8: got %b want 0001", bus8.gnt); end
    vectors++; if (bus0.gnt !== 4'b0001) begin miscompares++; $display("FAIL arst_restart0: got %b want 0001", bus0.gnt); end
    set_req(4'b0000);
    tick;
  endtask

  initial begin
    rst = 1'b1;
    set_req(4'b0000);
    test_reset;
    test_single_request;
    test_simultaneous;
    test_release_handover;
    test_lone_owner;
    test_max_burst0;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
